// File: rtl/parity_frame_if.sv
// Serial parity-frame bus: bit stream in, assembled word and status out.
// master drives the bit stream, slave is the checker.
interface parity_frame_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic              bit_in;
   logic              bit_valid;
   logic [DATA_W-1:0] data_out;
   logic              par_err;
   logic              out_valid;
   logic              busy;
   logic              abort;

   modport master (
      output start, bit_in, bit_valid,
      input  data_out, par_err, out_valid, busy, abort
   );

   modport slave (
      input  start, bit_in, bit_valid,
      output data_out, par_err, out_valid, busy, abort
   );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_W data bits LSB first, then one parity bit.
// Reports the word with a parity error flag; a restart discards the frame.
module parity_frame_checker #(
   parameter int DATA_W  = 8,
   parameter bit ODD_PAR = 1'b0
) (
   input logic           clk,
   input logic           rst,
   parity_frame_if.slave pf
);
   localparam int CW = $clog2(DATA_W) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              acc_q, acc_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              perr_q, perr_d;
   logic              ov_q, ov_d;
   logic              ab_q, ab_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ov_d    = 1'b0;
      ab_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pf.start) begin
               state_d = S_DATA;
               cnt_d   = '0;
               acc_d   = 1'b0;
            end
         end
         S_DATA: begin
            if (pf.start) begin
               ab_d  = 1'b1;
               cnt_d = '0;
               acc_d = 1'b0;
            end else if (pf.bit_valid) begin
               for (int i = 0; i < DATA_W; i++) begin
                  if (cnt_q == CW'(i)) sh_d[i] = pf.bit_in;
               end
               acc_d = acc_q ^ pf.bit_in;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            // a restart wins over a parity bit arriving in the same cycle
            if (pf.start) begin
               ab_d    = 1'b1;
               state_d = S_DATA;
               cnt_d   = '0;
               acc_d   = 1'b0;
            end else if (pf.bit_valid) begin
               data_d  = sh_q;
               perr_d  = acc_q ^ pf.bit_in ^ ODD_PAR;
               ov_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         sh_q    <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ov_q    <= 1'b0;
         ab_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ov_q    <= ov_d;
         ab_q    <= ab_d;
      end
   end

   assign pf.data_out  = data_q;
   assign pf.par_err   = perr_q;
   assign pf.out_valid = ov_q;
   assign pf.abort     = ab_q;
   assign pf.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench: even- and odd-parity checkers on one bit stream, table plus
// directed frames plus random traffic against a bit-list model.
module tb_parity_frame_checker;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic bv = 1'b0;
   logic b = 1'b0;

   always #5 clk = ~clk;

   parity_frame_if #(.DATA_W(W)) if0 ();
   parity_frame_if #(.DATA_W(W)) if1 ();

   assign if0.start     = start;
   assign if0.bit_in    = b;
   assign if0.bit_valid = bv;
   assign if1.start     = start;
   assign if1.bit_in    = b;
   assign if1.bit_valid = bv;

   parity_frame_checker #(.DATA_W(W), .ODD_PAR(1'b0)) dut0 (
      .clk(clk), .rst(rst), .pf(if0)
   );
   parity_frame_checker #(.DATA_W(W), .ODD_PAR(1'b1)) dut1 (
      .clk(clk), .rst(rst), .pf(if1)
   );

   int nvec = 0;
   int nerr = 0;
   int ov_cnt = 0;
   int ab_cnt = 0;
   int busy_low = 0;

   // reference model: list of accepted data bits of the open frame
   bit      m_in = 1'b0;
   bit      m_bits[$];
   bit [W-1:0] m_data[2];
   bit      m_perr[2];
   bit      m_ov = 1'b0;
   bit      m_ab = 1'b0;

   task automatic model(input bit r, s, v, bb);
      int ones;
      bit [W-1:0] w;
      m_ov = 1'b0;
      m_ab = 1'b0;
      if (r) begin
         m_in = 1'b0;
         m_bits.delete();
         m_data[0] = '0; m_data[1] = '0;
         m_perr[0] = 1'b0; m_perr[1] = 1'b0;
      end else if (s) begin
         m_ab = m_in;
         m_in = 1'b1;
         m_bits.delete();
      end else if (m_in && v) begin
         if (m_bits.size() < W) begin
            m_bits.push_back(bb);
         end else begin
            ones = 0;
            w = '0;
            for (int i = 0; i < W; i++) begin
               ones += int'(m_bits[i]);
               w += W'(m_bits[i]) << i;
            end
            m_data[0] = w; m_data[1] = w;
            m_perr[0] = bit'((ones + int'(bb)) % 2);
            m_perr[1] = bit'((ones + int'(bb) + 1) % 2);
            m_ov = 1'b1;
            m_in = 1'b0;
            m_bits.delete();
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit r, s, v, bb);
      logic [11:0] a0, a1, e0, e1;
      rst = r; start = s; bv = v; b = bb;
      @(posedge clk);
      #1;
      model(r, s, v, bb);
      a0 = {if0.data_out, if0.par_err, if0.out_valid, if0.busy, if0.abort};
      a1 = {if1.data_out, if1.par_err, if1.out_valid, if1.busy, if1.abort};
      e0 = {m_data[0], m_perr[0], m_ov, m_in, m_ab};
      e1 = {m_data[1], m_perr[1], m_ov, m_in, m_ab};
      chk("even_outputs", 32'(a0), 32'(e0));
      chk("odd_outputs", 32'(a1), 32'(e1));
      if (if0.out_valid === 1'b1) ov_cnt++;
      if (if0.abort === 1'b1) ab_cnt++;
      if (if0.busy !== 1'b1) busy_low++;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gap, 0)) cyc(0, 0, 0, 1'($urandom));
         cyc(0, 0, 1, w[i]);
      end
   endtask

   task automatic frame(input logic [W-1:0] w, input bit p, input int gap);
      cyc(0, 1, 1, 1'($urandom));
      send_bits(w, W, gap);
      repeat ($urandom_range(gap, 0)) cyc(0, 0, 0, 1'($urandom));
      cyc(0, 0, 1, p);
   endtask

   typedef struct {
      bit         r, s, v, bb;
      logic [7:0] ed;
      logic       ep, eo, eb, ea;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 1, 8'h00, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 1, 8'h00, 0, 0, 1, 0};
      tbl[3]  = '{0, 0, 1, 1, 8'h00, 0, 0, 1, 0};
      tbl[4]  = '{0, 0, 1, 0, 8'h00, 0, 0, 1, 0};
      tbl[5]  = '{0, 0, 1, 1, 8'h00, 0, 0, 1, 0};
      tbl[6]  = '{0, 0, 1, 0, 8'h00, 0, 0, 1, 0};
      tbl[7]  = '{0, 0, 1, 0, 8'h00, 0, 0, 1, 0};
      tbl[8]  = '{0, 0, 1, 1, 8'h00, 0, 0, 1, 0};
      tbl[9]  = '{0, 0, 1, 0, 8'h00, 0, 0, 1, 0};
      tbl[10] = '{0, 0, 1, 1, 8'h00, 0, 0, 1, 0};
      tbl[11] = '{0, 0, 1, 0, 8'hA5, 0, 1, 0, 0};
      tbl[12] = '{0, 0, 0, 0, 8'hA5, 0, 0, 0, 0};
      tbl[13] = '{0, 0, 1, 1, 8'hA5, 0, 0, 0, 0};

      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].bb);
         chk($sformatf("tbl%0d", i),
             32'({if0.data_out, if0.par_err, if0.out_valid,
                  if0.busy, if0.abort}),
             32'({tbl[i].ed, tbl[i].ep, tbl[i].eo, tbl[i].eb, tbl[i].ea}));
      end

      // A5 with parity 1: even checker flags, odd checker does not
      frame(8'hA5, 1'b1, 0);
      cyc(0, 0, 0, 0);
      chk("a5_p1_even_err", 32'(if0.par_err), 32'd1);
      chk("a5_p1_odd_err", 32'(if1.par_err), 32'd0);

      // FF with gaps, busy must stay high across the whole frame
      ov_cnt = 0;
      busy_low = 0;
      cyc(0, 1, 0, 0);
      send_bits(8'hFF, W, 3);
      repeat ($urandom_range(3, 0)) cyc(0, 0, 0, 0);
      chk("ff_busy", 32'(busy_low), 32'd0);
      cyc(0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0);
      chk("ff_ov_once", 32'(ov_cnt), 32'd1);
      chk("ff_data", 32'(if0.data_out), 32'hFF);
      chk("ff_perr", 32'(if0.par_err), 32'd0);

      // restart after 4 bits, then a full 3C frame
      ov_cnt = 0;
      ab_cnt = 0;
      cyc(0, 1, 0, 0);
      send_bits(8'h0F, 4, 0);
      frame(8'h3C, 1'b0, 0);
      repeat (2) cyc(0, 0, 0, 0);
      chk("restart_abort", 32'(ab_cnt), 32'd1);
      chk("restart_ov", 32'(ov_cnt), 32'd1);
      chk("restart_data", 32'(if0.data_out), 32'h3C);
      chk("restart_perr", 32'(if0.par_err), 32'd0);

      // restart on the parity cycle wins over the parity bit
      ov_cnt = 0;
      ab_cnt = 0;
      cyc(0, 1, 0, 0);
      send_bits(8'h81, W, 0);
      cyc(0, 1, 1, 0);
      chk("par_restart_abort", 32'(ab_cnt), 32'd1);
      chk("par_restart_ov", 32'(ov_cnt), 32'd0);
      chk("par_restart_data", 32'(if0.data_out), 32'h3C);

      // reset after 5 bits, then a full 01 frame with parity 1
      ov_cnt = 0;
      ab_cnt = 0;
      send_bits(8'h1F, 5, 0);
      cyc(1, 1, 1, 1);
      chk("rst_ov", 32'(ov_cnt), 32'd0);
      chk("rst_abort", 32'(ab_cnt), 32'd0);
      chk("rst_data", 32'(if0.data_out), 32'd0);
      chk("rst_busy", 32'(if0.busy), 32'd0);
      frame(8'h01, 1'b1, 0);
      cyc(0, 0, 0, 0);
      chk("post_rst_data", 32'(if0.data_out), 32'h01);
      chk("post_rst_perr", 32'(if0.par_err), 32'd0);
      chk("post_rst_ov", 32'(ov_cnt), 32'd1);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(199, 0) == 0),
             ($urandom_range(24, 0) == 0),
             1'($urandom),
             1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
